instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; word aligned.
REQ-002 Parameter DEPTH, default 4, instruction buffer entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address; equals internal PC register.
REQ-007 imem_gnt  input  1  memory accepts request this cycle; counts only when imem_req=1.
REQ-008 imem_rvalid  input  1  fetch data returned this cycle.
REQ-009 imem_rdata  input  32  returned instruction word.
REQ-010 redirect_valid  input  1  taken branch, jump or jalr from execute; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch target; bits [1:0] ignored and treated as 0.
REQ-012 instr_valid  output  1  buffer head holds a valid instruction for the opcode decoder.
REQ-013 instruction  output  32  head instruction word; feeds the decoder's instruction input.
REQ-014 instr_pc  output  32  address the head instruction was fetched from.
REQ-015 instr_ready  input  1  decoder accepts the head this cycle.

Function
REQ-016 FSM states: REQ (may issue), WAIT (one request granted, response pending), DROP (stale response pending, discard it).
REQ-017 At most one outstanding memory request at any time.
REQ-018 imem_req = (state==REQ) and (count < DEPTH) and not redirect_valid; combinational.
REQ-019 imem_addr is held stable while imem_req=1 and not granted.
REQ-020 REQ with imem_req=1 and imem_gnt=1: latch req_pc<=pc, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go to WAIT.
REQ-021 WAIT with imem_rvalid=1: push {req_pc, imem_rdata} at the tail, go to REQ; a response may arrive the cycle after grant or later.
REQ-022 imem_rvalid outside WAIT/DROP is ignored.
REQ-023 Buffer is a circular FIFO; read and write pointers wrap at DEPTH; count range 0..DEPTH.
REQ-024 instr_valid = (count != 0); instruction and instr_pc present the head entry.
REQ-025 Pop when instr_valid and instr_ready; push and pop in the same cycle leave count unchanged.
REQ-026 Overflow cannot occur: a request is never issued while count==DEPTH.
REQ-027 Latency: the word returned on cycle N is visible on instruction with instr_valid=1 on cycle N+1 when the buffer was empty.
REQ-028 Program order preserved: instr_pc of consecutive popped entries differs by 4 unless a redirect occurred between them.
REQ-029 redirect_valid=1 (highest priority, any state): count<=0, pointers<=0, pc<=redirect_pc with bits[1:0]=0.
REQ-030 Same-cycle push or pop is cancelled by redirect.
REQ-031 Redirect in REQ: stay REQ; next request uses the new PC on the following cycle.
REQ-032 Redirect in WAIT without imem_rvalid: go to DROP. Redirect in WAIT with imem_rvalid: data discarded, go to REQ.
REQ-033 DROP: imem_rvalid discards data and moves to REQ; a further redirect updates pc and stays in DROP.
REQ-034 Consecutive redirects: the last one wins; no stale instruction is ever presented after a redirect.

Reset
REQ-035 On rst_n low, immediately and asynchronously: state=REQ, pc=RESET_PC, count=0, pointers=0, req_pc=0, all buffer entries=0.
REQ-036 During reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0.
REQ-037 Reset mid-fetch abandons any outstanding request; imem_rvalid after reset release with state REQ is ignored.
REQ-038 First request is issued in the first cycle after rst_n deasserts.

Verification
REQ-039 Reset release, memory grants immediately and returns rdata=32'h0000_0013 one cycle later, instr_ready=1 -> instr_valid=1 with instr_pc=0, then instr_pc=4, 8, ... once per two cycles.
REQ-040 instr_ready=0 held with a granting memory, DEPTH=4 -> 4 entries buffered, imem_req=0; then instr_ready=1 -> 4 pops with pc 0,4,8,12 in order, fetching resumes.
REQ-041 Redirect to 32'h0000_0100 while in WAIT -> next imem_rvalid data dropped; next imem_addr=32'h100; first instr_pc presented = 32'h100.
REQ-042 redirect_pc=32'h0000_0203 -> imem_addr=32'h0000_0200.
REQ-043 Redirect to 32'hFFFF_FFFC -> two fetches present instr_pc FFFF_FFFC then 0000_0000.
REQ-044 rst_n asserted while in WAIT with 2 buffered entries -> outputs return to reset values in the same cycle; stray imem_rvalid after release never produces instr_valid.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: single-outstanding memory fetcher feeding a circular instruction buffer.
// Latency: a word returned on cycle N is presented at the buffer head on cycle N+1.
// Backpressure: decoder stalls via instr_ready=0; no new request issues while the buffer is full.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   pc_mem_d    [DEPTH];
  logic          push;
  logic          pop;

  // Request is gated by reset so nothing is presented to memory while held in reset.
  assign imem_req    = rst_n && (state_q == S_REQ) && (count_q < DEPTH_C) && !redirect_valid;
  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != '0);
  assign instruction = instr_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];

  // Fetch FSM, PC tracking and buffer pointer/count update; redirect overrides everything.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push     = 1'b0;
    pop      = 1'b0;

    case (state_q)
      S_REQ: begin
        if (imem_req && imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    pop = instr_valid && instr_ready;

    if (redirect_valid) begin
      // Flush: cancel same-cycle push/pop; an in-flight response must be discarded.
      push     = 1'b0;
      pop      = 1'b0;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pc_d     = {redirect_pc[31:2], 2'b00};
      case (state_q)
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer write: returned word and its fetch address land at the tail slot.
  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (push) begin
      instr_mem_d[wr_ptr_q] = imem_rdata;
      pc_mem_d[wr_ptr_q]    = req_pc_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4, RESET_PC=0).
// Inputs are driven 1 time unit after each rising edge; outputs checked shortly after.
// Memory responses are scripted cycle by cycle.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b1;
    imem_gnt       = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    // Reset outputs (grant held high to show request stays low in reset).
    chk1 ("rst_req",   imem_req,    1'b0);
    chk32("rst_addr",  imem_addr,   32'h0);
    chk1 ("rst_valid", instr_valid, 1'b0);
    chk32("rst_instr", instruction, 32'h0);
    chk32("rst_ipc",   instr_pc,    32'h0);
    tick();
    tick();

    // Streaming fetch: grant immediately, data one cycle later, decoder always ready.
    rst_n = 1'b1; instr_ready = 1'b1; #1;
    chk1 ("s_req0",  imem_req,  1'b1);
    chk32("s_addr0", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; #1;
    chk1 ("s_req_wait", imem_req, 1'b0);
    chk32("s_addr1",    imem_addr, 32'h4);
    chk1 ("s_val_wait", instr_valid, 1'b0);
    tick();
    imem_rvalid = 1'b0; #1;
    chk1 ("s_val0",   instr_valid, 1'b1);
    chk32("s_instr0", instruction, 32'h0000_0013);
    chk32("s_ipc0",   instr_pc,    32'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; #1;
    chk1 ("s_val_gap", instr_valid, 1'b0);
    tick();
    imem_rvalid = 1'b0; #1;
    chk1 ("s_val1", instr_valid, 1'b1);
    chk32("s_ipc1", instr_pc,    32'h4);
    tick();
    imem_rvalid = 1'b1; #1;
    tick();
    imem_rvalid = 1'b0; #1;
    chk32("s_ipc2", instr_pc, 32'h8);

    // Flush to 0, then fill the buffer with the decoder stalled.
    redirect_valid = 1'b1; redirect_pc = 32'h0; instr_ready = 1'b0; #1;
    chk1("f_req_redir", imem_req, 1'b0);
    tick();
    redirect_valid = 1'b0; #1;
    chk1("f_val_flush", instr_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk1 ($sformatf("f_req%0d", k),  imem_req,  1'b1);
      chk32($sformatf("f_addr%0d", k), imem_addr, 32'(4 * k));
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'h1000 + 32'(k); #1;
      tick();
      imem_rvalid = 1'b0; #1;
    end
    chk1 ("f_full_req", imem_req,    1'b0);
    chk1 ("f_full_val", instr_valid, 1'b1);
    tick();
    chk1 ("f_full_req2", imem_req,  1'b0);
    chk32("f_full_addr", imem_addr, 32'h10);

    // Drain with grant withheld: entries in order, request returns at a stable address.
    imem_gnt = 1'b0; instr_ready = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      chk1 ($sformatf("d_val%0d", k),   instr_valid, 1'b1);
      chk32($sformatf("d_ipc%0d", k),   instr_pc,    32'(4 * k));
      chk32($sformatf("d_instr%0d", k), instruction, 32'h1000 + 32'(k));
      tick();
      if (k == 0) begin
        chk1 ("d_req_resume", imem_req,  1'b1);
        chk32("d_addr_hold",  imem_addr, 32'h10);
      end
    end
    chk1 ("d_empty",      instr_valid, 1'b0);
    chk32("d_addr_hold2", imem_addr,   32'h10);

    // Redirect while WAIT -> DROP; second redirect in DROP wins; stale data discarded.
    imem_gnt = 1'b1; #1;
    tick();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0180; #1;
    chk1("r_req_wait", imem_req, 1'b0);
    tick();
    redirect_pc = 32'h0000_0100; #1;
    tick();
    redirect_valid = 1'b0; #1;
    chk1 ("r_req_drop",  imem_req,  1'b0);
    chk32("r_addr_drop", imem_addr, 32'h100);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    tick();
    imem_rvalid = 1'b0; #1;
    chk1 ("r_val_dropped", instr_valid, 1'b0);
    chk1 ("r_req_after",   imem_req,    1'b1);
    chk32("r_addr_after",  imem_addr,   32'h100);
    imem_gnt = 1'b1; #1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_2000; #1;
    tick();
    imem_rvalid = 1'b0; #1;
    chk1 ("r_val_new",   instr_valid, 1'b1);
    chk32("r_ipc_new",   instr_pc,    32'h100);
    chk32("r_instr_new", instruction, 32'h0000_2000);

    // Unaligned redirect target; also cancels the pending pop.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; imem_gnt = 1'b1; #1;
    tick();
    redirect_valid = 1'b0; #1;
    chk32("u_addr",  imem_addr,   32'h200);
    chk1 ("u_val",   instr_valid, 1'b0);
    chk1 ("u_req",   imem_req,    1'b1);
    tick();
    // Redirect with response in the same WAIT cycle: data dropped, back to REQ.
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    tick();
    imem_rvalid = 1'b0; redirect_valid = 1'b0; #1;
    chk1 ("w_val",  instr_valid, 1'b0);
    chk32("w_addr", imem_addr,   32'hFFFF_FFFC);
    chk1 ("w_req",  imem_req,    1'b1);

    // PC wrap from FFFF_FFFC to 0.
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_3000; #1;
    chk32("x_addr_wrap", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b0; #1;
    chk32("x_ipc0", instr_pc, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_3001; instr_ready = 1'b0; #1;
    tick();
    imem_rvalid = 1'b0; #1;
    chk1 ("x_val1",   instr_valid, 1'b1);
    chk32("x_ipc1",   instr_pc,    32'h0);
    chk32("x_instr1", instruction, 32'h0000_3001);

    // Build WAIT with two buffered entries, then reset asynchronously mid-cycle.
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_3002; #1;
    tick();
    imem_rvalid = 1'b0; #1;
    tick();
    chk1("m_val_pre", instr_valid, 1'b1);
    chk1("m_req_pre", imem_req,    1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk1 ("m_req",   imem_req,    1'b0);
    chk32("m_addr",  imem_addr,   32'h0);
    chk1 ("m_val",   instr_valid, 1'b0);
    chk32("m_instr", instruction, 32'h0);
    chk32("m_ipc",   instr_pc,    32'h0);
    tick();
    rst_n = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001; #1;
    chk1("m_req_rel", imem_req, 1'b1);
    tick();
    imem_rvalid = 1'b0; #1;
    chk1("m_stray0", instr_valid, 1'b0);
    tick();
    chk1 ("m_stray1",   instr_valid, 1'b0);
    chk32("m_addr_rel", imem_addr,   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
